pong_motion: RTL and testbench

- Game-state engine directly upstream of the pong renderer.
- Once per video frame it updates the paddle's vertical position from the player buttons. It also moves the ball, resolves bounces off the top, bottom, left wall and paddle, and detects a miss.
- Outputs are registered object coordinates that the renderer compares against the current pixel x/y to draw the paddle and ball.

---
 rtl/pong_motion.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pong_motion.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_motion.sv
// ---------------------------------------------------------------------------
// pong_motion -- per-frame game-state engine feeding the pong renderer.
//
// Once per video frame (frame_tick) the paddle is stepped from the player
// buttons. The ball is advanced, bounced off the top/bottom/left wall/paddle,
// and a miss past the paddle is detected. All object coordinates are
// registered and hold between ticks.
//
// Ports:
//   CLK          in   pixel clock (same as the VGA timing generator)
//   RST_N        in   asynchronous active-low reset
//   frame_tick   in   one-CLK pulse per frame (start of vertical blank)
//   BTN_UP       in   raw async button, paddle up
//   BTN_DN       in   raw async button, paddle down
//   bar_y_t      out  paddle top y
//   ball_x       out  ball left x
//   ball_y       out  ball top y
//   ball_active  out  ball visible (renderer gates the ball with it)
//   miss         out  one-CLK pulse when the ball passes the paddle
//
// Build option:
//   AUTO_PADDLE_EN  when defined, the paddle tracks the ball centre and the
//                   buttons are ignored; SERVE exits on the first tick.
// ---------------------------------------------------------------------------
module pong_motion #(
  parameter int BAR_V        = 4,
  parameter int BALL_V       = 2,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       BTN_UP,
  input  logic       BTN_DN,
  output logic [9:0] bar_y_t,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic       miss
);

  // Geometry shared with the renderer.
  localparam int MAX_X      = 640;
  localparam int MAX_Y      = 480;
  localparam int WALL_X_R   = 35;
  localparam int BAR_X_L    = 580;
  localparam int BAR_X_R    = 583;
  localparam int BAR_Y_SIZE = 72;
  localparam int BALL_SIZE  = 8;
  localparam int SERVE_X    = 320;
  localparam int SERVE_Y    = 236;

  // Derived limits, all in the 11-bit domain so sums never wrap.
  localparam logic [10:0] C_BAR_V    = 11'(BAR_V);
  localparam logic [10:0] C_BALL_V   = 11'(BALL_V);
  localparam logic [10:0] C_BAR_MAX  = 11'(MAX_Y - BAR_Y_SIZE);       // 408
  localparam logic [10:0] C_BAR_HALF = 11'(BAR_Y_SIZE / 2);           // 36
  localparam logic [10:0] C_BAR_SPAN = 11'(BAR_Y_SIZE - 1);           // 71
  localparam logic [10:0] C_BALL_HALF= 11'(BALL_SIZE / 2);            // 4
  localparam logic [10:0] C_BALL_SPAN= 11'(BALL_SIZE - 1);            // 7
  localparam logic [10:0] C_Y_BOT    = 11'(MAX_Y - BALL_SIZE);        // 472
  localparam logic [10:0] C_X_WALL   = 11'(WALL_X_R + 1);             // 36
  localparam logic [10:0] C_X_PAD    = 11'(BAR_X_L - BALL_SIZE);      // 572
  localparam logic [10:0] C_X_MISS   = 11'(MAX_X - BALL_SIZE);        // 632
  localparam logic [9:0]  C_BAR_RST  = 10'((MAX_Y - BAR_Y_SIZE) / 2); // 204
  localparam logic [9:0]  C_SERVE_X  = 10'(SERVE_X);
  localparam logic [9:0]  C_SERVE_Y  = 10'(SERVE_Y);

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } state_t;

  // Per-axis result of one ball step.
  typedef struct packed {
    logic [9:0] pos;
    logic       dir_pos;  // 1 = moving toward larger coordinate
  } axis_t;

  state_t           state;
  logic             dx_pos, dy_pos;
  logic [CNT_W-1:0] cnt;

  // ---------------------------------------------------------------------
  // Button synchronisers (2 flops each).
  // ---------------------------------------------------------------------
  logic [1:0] up_sync, dn_sync;
  logic       up_s, dn_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      up_sync <= '0;
      dn_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], BTN_UP};
      dn_sync <= {dn_sync[0], BTN_DN};
    end
  end

  assign up_s = up_sync[1];
  assign dn_s = dn_sync[1];

  // ---------------------------------------------------------------------
  // Paddle step.
  // ---------------------------------------------------------------------
  logic [10:0] bar11, x11, y11;
  logic        go_up, go_dn, serve_go;
  logic [10:0] bar_sum;
  logic [9:0]  bar_nxt;

  assign bar11 = {1'b0, bar_y_t};
  assign x11   = {1'b0, ball_x};
  assign y11   = {1'b0, ball_y};

`ifdef AUTO_PADDLE_EN
  // Track the ball: compare ball centre against paddle centre.
  logic [10:0] ball_ctr, bar_ctr;
  assign ball_ctr = y11 + C_BALL_HALF;
  assign bar_ctr  = bar11 + C_BAR_HALF;
  assign go_up    = (ball_ctr < bar_ctr);
  assign go_dn    = (ball_ctr > bar_ctr);
  assign serve_go = 1'b1;
`else
  // Both buttons together cancel out.
  assign go_up    = up_s & ~dn_s;
  assign go_dn    = dn_s & ~up_s;
  assign serve_go = up_s | dn_s;
`endif

  assign bar_sum = bar11 + C_BAR_V;

  always_comb begin
    bar_nxt = bar_y_t;
    if (go_up) begin
      if (bar11 < C_BAR_V) bar_nxt = '0;
      else                 bar_nxt = bar_y_t - 10'(BAR_V);
    end else if (go_dn) begin
      if (bar_sum > C_BAR_MAX) bar_nxt = C_BAR_MAX[9:0];
      else                     bar_nxt = bar_sum[9:0];
    end
  end

  // ---------------------------------------------------------------------
  // Ball step, evaluated on pre-tick positions. The two axes are
  // independent so a corner hit flips both directions in one tick.
  // ---------------------------------------------------------------------
  axis_t       y_step, x_step;
  logic        x_miss;
  logic        pad_overlap;
  logic [10:0] y_sum, x_sum;

  assign y_sum = y11 + C_BALL_V;
  assign x_sum = x11 + C_BALL_V;

  always_comb begin
    y_step.pos     = ball_y;
    y_step.dir_pos = dy_pos;
    if (!dy_pos) begin
      if (y11 < C_BALL_V) begin
        y_step.pos     = '0;
        y_step.dir_pos = 1'b1;
      end else begin
        y_step.pos = ball_y - 10'(BALL_V);
      end
    end else begin
      if (y_sum > C_Y_BOT) begin
        y_step.pos     = C_Y_BOT[9:0];
        y_step.dir_pos = 1'b0;
      end else begin
        y_step.pos = y_sum[9:0];
      end
    end
  end

  assign pad_overlap = (y11 + C_BALL_SPAN >= bar11) &&
                       (y11 <= bar11 + C_BAR_SPAN);

  always_comb begin
    x_step.pos     = ball_x;
    x_step.dir_pos = dx_pos;
    x_miss         = 1'b0;
    if (!dx_pos) begin
      if (x11 < C_X_WALL + C_BALL_V) begin
        x_step.pos     = C_X_WALL[9:0];
        x_step.dir_pos = 1'b1;
      end else begin
        x_step.pos = ball_x - 10'(BALL_V);
      end
    end else begin
      // Paddle face is crossed this tick: snap to the face and reflect.
      if ((x11 <= C_X_PAD) && (x_sum > C_X_PAD) && pad_overlap) begin
        x_step.pos     = C_X_PAD[9:0];
        x_step.dir_pos = 1'b0;
      end else if (x_sum > C_X_MISS) begin
        x_miss = 1'b1;  // position holds; FSM takes over
      end else begin
        x_step.pos = x_sum[9:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Game FSM with registered outputs.
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= SERVE;
      dx_pos      <= 1'b0;
      dy_pos      <= 1'b1;
      cnt         <= '0;
      bar_y_t     <= C_BAR_RST;
      ball_x      <= C_SERVE_X;
      ball_y      <= C_SERVE_Y;
      ball_active <= 1'b1;
      miss        <= 1'b0;
    end else begin
      miss <= 1'b0;
      if (frame_tick) begin
        bar_y_t <= bar_nxt;
        case (state)
          SERVE: begin
            ball_x      <= C_SERVE_X;
            ball_y      <= C_SERVE_Y;
            ball_active <= 1'b1;
            if (serve_go) begin
              dx_pos <= 1'b0;
              dy_pos <= 1'b1;
              state  <= PLAY;
            end
          end
          PLAY: begin
            ball_y <= y_step.pos;
            dy_pos <= y_step.dir_pos;
            if (x_miss) begin
              miss        <= 1'b1;
              ball_active <= 1'b0;
              cnt         <= '0;
              state       <= MISS;
            end else begin
              ball_x <= x_step.pos;
              dx_pos <= x_step.dir_pos;
            end
          end
          MISS: begin
            if (cnt == C_CNT_LAST) begin
              cnt         <= '0;
              ball_x      <= C_SERVE_X;
              ball_y      <= C_SERVE_Y;
              ball_active <= 1'b1;
              state       <= SERVE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= SERVE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pong_motion.sv
// ---------------------------------------------------------------------------
// tb_pong_motion -- self-checking bench for pong_motion.
// A behavioural game model (plain integer arithmetic) advances once per
// frame tick; DUT outputs are sampled on the falling edge after each tick.
// ---------------------------------------------------------------------------
module tb_pong_motion;
  localparam int BAR_V = 4, BALL_V = 2, SERVE_FRAMES = 60;

  logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_dn = 1'b0;
  logic [9:0] bar_y_t, ball_x, ball_y;
  logic       ball_active, miss;

  always #5 clk = ~clk;

  pong_motion #(.BAR_V(BAR_V), .BALL_V(BALL_V), .SERVE_FRAMES(SERVE_FRAMES)) dut (
    .CLK(clk), .RST_N(rst_n), .frame_tick(frame_tick),
    .BTN_UP(btn_up), .BTN_DN(btn_dn),
    .bar_y_t(bar_y_t), .ball_x(ball_x), .ball_y(ball_y),
    .ball_active(ball_active), .miss(miss)
  );

  int checks = 0, errors = 0;

  // Behavioural model: field layout of the packed vectors is bar|x|y|act|miss.
  int m_bar, m_x, m_y, m_dx, m_dy, m_state, m_cnt, m_active, m_miss, m_hit;
  logic [31:0] dut_v;
  assign dut_v = {bar_y_t, ball_x, ball_y, ball_active, miss};

  function automatic logic [31:0] exp_vec();
    return {10'(m_bar), 10'(m_x), 10'(m_y), 1'(m_active), 1'(m_miss)};
  endfunction

  task automatic model_reset();
    m_bar = 204; m_x = 320; m_y = 236; m_dx = -1; m_dy = 1;
    m_state = 0; m_cnt = 0; m_active = 1; m_miss = 0; m_hit = 0;
  endtask

  task automatic model_step(input bit up, input bit dn);
    int dir, nb, nx, ny, ndx, ndy;
    bit go;
`ifdef AUTO_PADDLE_EN
    dir = (m_y + 4 < m_bar + 36) ? -1 : (m_y + 4 > m_bar + 36) ? 1 : 0;
    go  = 1'b1;
`else
    dir = (up && !dn) ? -1 : (dn && !up) ? 1 : 0;
    go  = up || dn;
`endif
    nb = m_bar + dir * BAR_V;
    if (nb < 0)   nb = 0;
    if (nb > 408) nb = 408;
    m_miss = 0; m_hit = 0;
    case (m_state)
      0: if (go) begin m_state = 1; m_dx = -1; m_dy = 1; end
      1: begin
        ny = m_y + m_dy * BALL_V; ndy = m_dy;
        if (ny < 0)   begin ny = 0;   ndy = 1;  end
        if (ny > 472) begin ny = 472; ndy = -1; end
        nx = m_x + m_dx * BALL_V; ndx = m_dx;
        if (m_dx < 0 && nx < 36) begin nx = 36; ndx = 1; end
        else if (m_dx > 0 && m_x <= 572 && nx > 572 &&
                 m_y + 7 >= m_bar && m_y <= m_bar + 71) begin
          nx = 572; ndx = -1; m_hit = 1;
        end else if (m_dx > 0 && nx > 632) begin
          nx = m_x; m_miss = 1; m_active = 0; m_cnt = 0; m_state = 2;
        end
        m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
      end
      default: begin
        if (m_cnt == SERVE_FRAMES - 1) begin
          m_cnt = 0; m_x = 320; m_y = 236; m_active = 1; m_state = 0;
        end else m_cnt++;
      end
    endcase
    m_bar = nb;
  endtask

  // Drive buttons, let the synchronisers settle, pulse one tick, step model.
  // Returns at the falling edge right after the tick edge.
  task automatic tick(input bit up, input bit dn);
    @(negedge clk); btn_up = up; btn_dn = dn;
    repeat (3) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_step(up, dn);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; frame_tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0; model_reset();
    #1;
    checks++;
    if (dut_v !== exp_vec()) begin
      errors++; $display("FAIL reset_hold: got %h want %h", dut_v, exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (dut_v !== 32'({10'd204, 10'd320, 10'd236, 1'b1, 1'b0})) begin
        errors++; $display("FAIL reset_idle cyc %0d: got %h", i, dut_v);
      end
    end
  endtask

  task automatic test_paddle_clamp();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      tick(1, 0);
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL paddle_up t%0d: got %h want %h", i, dut_v, exp_vec());
      end
    end
    checks++;
    if (bar_y_t !== 10'd0) begin
      errors++; $display("FAIL paddle_top_clamp: got %0d want 0", bar_y_t);
    end
    for (int i = 0; i < 110; i++) begin
      tick(0, 1);
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL paddle_dn t%0d: got %h want %h", i, dut_v, exp_vec());
      end
    end
    checks++;
    if (bar_y_t !== 10'd408) begin
      errors++; $display("FAIL paddle_bot_clamp: got %0d want 408", bar_y_t);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 1);
      checks++;
      if (bar_y_t !== 10'd408 || dut_v !== exp_vec()) begin
        errors++; $display("FAIL paddle_both t%0d: got %h want %h", i, dut_v, exp_vec());
      end
    end
  endtask

  task automatic test_wall_bounce();
    bit seen_bot = 0;
    do_reset();
    tick(0, 0);  // no button: serve holds
    checks++;
    if (dut_v !== exp_vec() || ball_x !== 10'd320) begin
      errors++; $display("FAIL serve_hold: got %h want %h", dut_v, exp_vec());
    end
    tick(1, 0);  // serve; ball does not move on this tick
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd236 || dut_v !== exp_vec()) begin
      errors++; $display("FAIL serve_start: got %h want %h", dut_v, exp_vec());
    end
    for (int i = 1; i <= 145; i++) begin
      tick(0, 0);
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL wall t%0d: got %h want %h", i, dut_v, exp_vec());
      end
      if (i == 139) begin
        checks++;
        if (ball_x !== 10'd42) begin
          errors++; $display("FAIL wall_x139: got %0d want 42", ball_x);
        end
      end
      if (ball_y == 10'd472) seen_bot = 1;
    end
    checks++;
    if (ball_x !== 10'd40 || !seen_bot) begin  // 36 -> 36(flip) -> 38 -> 40 at tick 145
      errors++; $display("FAIL wall_flip: got x=%0d bot=%0d want 40/1", ball_x, seen_bot);
    end
  endtask

  // Bench steers the paddle toward the ball so the paddle face is exercised.
  task automatic test_paddle_hit();
    int hits = 0, tgt;
    bit up, dn;
    do_reset();
    tick(1, 0);
    for (int i = 0; i < 900; i++) begin
      tgt = m_y + 4 - 36;
      up = (m_bar > tgt + 2); dn = (m_bar < tgt - 2);
      tick(up, dn);
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL rally t%0d: got %h want %h", i, dut_v, exp_vec());
      end
      if (m_hit) begin
        hits++;
        checks++;
        if (ball_x !== 10'd572 || miss !== 1'b0) begin
          errors++; $display("FAIL paddle_face: got x=%0d miss=%0d want 572/0", ball_x, miss);
        end
      end
    end
    checks++;
    if (hits == 0) begin
      errors++; $display("FAIL rally_hits: got 0 want >0");
    end
  endtask

  task automatic test_miss();
    int n = 0;
    do_reset();
    tick(1, 0);
    while (!m_miss && n < 1000) begin
      tick(1, 0);  // paddle pinned at the top; ball passes below
      n++;
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL to_miss t%0d: got %h want %h", n, dut_v, exp_vec());
      end
    end
    checks++;
    if (!m_miss || miss !== 1'b1 || ball_active !== 1'b0 || ball_x !== 10'd632) begin
      errors++; $display("FAIL miss_pulse: got miss=%0d act=%0d x=%0d want 1/0/632",
                         miss, ball_active, ball_x);
    end
    @(negedge clk);
    m_miss = 0;
    checks++;
    if (miss !== 1'b0 || dut_v !== exp_vec()) begin
      errors++; $display("FAIL miss_one_cycle: got %h want %h", dut_v, exp_vec());
    end
    for (int i = 1; i <= SERVE_FRAMES; i++) begin
      tick(0, 0);
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL miss_wait t%0d: got %h want %h", i, dut_v, exp_vec());
      end
    end
    checks++;
    if (ball_x !== 10'd320 || ball_y !== 10'd236 || ball_active !== 1'b1) begin
      errors++; $display("FAIL reserve: got (%0d,%0d) act=%0d want (320,236) 1",
                         ball_x, ball_y, ball_active);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    tick(0, 1);
    for (int i = 0; i < 20; i++) tick(0, 1);
    @(negedge clk); #1;
    rst_n = 1'b0; model_reset();
    #1;
    checks++;
    if (dut_v !== exp_vec()) begin
      errors++; $display("FAIL async_reset: got %h want %h", dut_v, exp_vec());
    end
    @(negedge clk); rst_n = 1'b1;
    tick(1, 0);
    checks++;
    if (dut_v !== exp_vec()) begin
      errors++; $display("FAIL post_reset_serve: got %h want %h", dut_v, exp_vec());
    end
    tick(0, 0);
    checks++;
    if (dut_v !== exp_vec() || ball_x !== 10'd318) begin
      errors++; $display("FAIL post_reset_play: got %h want %h", dut_v, exp_vec());
    end
  endtask

  task automatic test_random();
    bit up, dn;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      up = 1'($urandom_range(0, 1)); dn = 1'($urandom_range(0, 1));
      tick(up, dn);
      checks++;
      if (dut_v !== exp_vec()) begin
        errors++; $display("FAIL random t%0d: got %h want %h", i, dut_v, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_paddle_clamp();
    test_wall_bounce();
    test_paddle_hit();
    test_miss();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
